// File: rtl/core_reset_pkg.sv
// Shared types and elaboration helpers for the core reset sequencer.
package core_reset_pkg;

  typedef enum logic [1:0] {HOLD, RELEASE, RUN, SWRST} reset_seq_state_t;

  // Upper bound on outputs per instance; release offsets are packed into this many slots.
  localparam int MAX_OUTPUTS = 32;
  typedef logic [MAX_OUTPUTS-1:0][31:0] rel_vec_t;

  function automatic int max_release(input rel_vec_t rel, input int n);
    int m;
    m = 0;
    for (int i = 0; i < MAX_OUTPUTS; i++) begin
      if (i < n && int'(rel[i]) > m) m = int'(rel[i]);
    end
    return m;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/core_bit_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
module core_bit_sync #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sync_q <= {DEPTH{RST_VAL}};
    end else begin
      sync_q[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign o_q = sync_q[DEPTH-1];

endmodule

// File: rtl/core_reset_seq.sv
// Staggered reset sequencer for one clock domain, gated by a filtered PLL lock.
// Define CORE_RESET_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter.
module core_reset_seq
  import core_reset_pkg::*;
#(
  parameter int NUM_OUTPUTS                      = 1,
  parameter int RELEASE_CLKS [0:NUM_OUTPUTS-1]   = '{default:0},
  parameter int LOCK_FILT_CLKS                   = 16,
  parameter int SW_RST_CLKS                      = 16,
  parameter int LOSS_CNT_BITS                    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_pll_locked,
  input  logic                     i_sw_rst_req,
  output logic [NUM_OUTPUTS-1:0]   o_srsts,
  output logic                     o_seq_done,
  output logic [LOSS_CNT_BITS-1:0] o_lock_loss_cnt,
  output reset_seq_state_t         o_dbg_state
);

  // NUM_OUTPUTS must not exceed MAX_OUTPUTS.
  function automatic rel_vec_t pack_rel();
    rel_vec_t v;
    v = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) v[i] = RELEASE_CLKS[i];
    return v;
  endfunction

  localparam int MAX_REL = max_release(pack_rel(), NUM_OUTPUTS);
  localparam int FILT_W  = cnt_width(LOCK_FILT_CLKS);
  localparam int REL_W   = cnt_width(MAX_REL);
  localparam int SW_W    = cnt_width(SW_RST_CLKS - 1);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT_CLKS - 1);
  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(MAX_REL);
  localparam logic [SW_W-1:0]   SW_LAST   = SW_W'(SW_RST_CLKS - 1);

  logic                   lock_s;
  reset_seq_state_t       state_q, state_d;
  logic [FILT_W-1:0]      filt_q;
  logic [REL_W-1:0]       rel_q;
  logic [SW_W-1:0]        sw_q;
  logic [NUM_OUTPUTS-1:0] srsts_q, srsts_d;
  logic                   done_q;

  core_bit_sync #(.DEPTH(2), .RST_VAL(1'b0)) u_lock_sync (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_d      (i_pll_locked),
    .o_q      (lock_s)
  );

  // Lock loss outranks a software request in every non-HOLD state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:    if (lock_s && filt_q == FILT_LAST) state_d = RELEASE;
      RELEASE: begin
        if (!lock_s)                state_d = HOLD;
        else if (i_sw_rst_req)      state_d = SWRST;
        else if (rel_q == REL_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lock_s)           state_d = HOLD;
        else if (i_sw_rst_req) state_d = SWRST;
      end
      SWRST: begin
        if (!lock_s)              state_d = HOLD;
        else if (sw_q == SW_LAST) state_d = RELEASE;
      end
      default: state_d = HOLD;
    endcase
  end

  // Outputs are registered from the next state so assertion lands on the deciding edge.
  always_comb begin
    srsts_d = '1;
    case (state_d)
      RELEASE: begin
        if (state_q == RELEASE) begin
          for (int i = 0; i < NUM_OUTPUTS; i++)
            srsts_d[i] = srsts_q[i] & (int'(rel_q) != RELEASE_CLKS[i]);
        end
      end
      RUN:     srsts_d = '0;
      default: srsts_d = '1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= HOLD;
      srsts_q <= '1;
      done_q  <= 1'b0;
      filt_q  <= '0;
      rel_q   <= '0;
      sw_q    <= '0;
    end else begin
      state_q <= state_d;
      srsts_q <= srsts_d;
      done_q  <= (state_d == RUN);
      filt_q  <= (state_q == HOLD && lock_s) ? filt_q + 1'b1 : '0;
      rel_q   <= (state_q == RELEASE) ? rel_q + 1'b1 : '0;
      sw_q    <= (state_q == SWRST) ? sw_q + 1'b1 : '0;
    end
  end

`ifdef CORE_RESET_SEQ_LOSS_CNT_EN
  logic                     lock_loss;
  logic [LOSS_CNT_BITS-1:0] loss_cnt_q;

  assign lock_loss = (state_q != HOLD) && !lock_s;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)                       loss_cnt_q <= '0;
    else if (lock_loss && ~&loss_cnt_q)  loss_cnt_q <= loss_cnt_q + 1'b1;
  end

  assign o_lock_loss_cnt = loss_cnt_q;
`else
  assign o_lock_loss_cnt = '0;
`endif

  assign o_srsts     = srsts_q;
  assign o_seq_done  = done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_core_reset_seq.sv
// Randomised scenario bench for core_reset_seq with a timestamped output-event scoreboard.
`timescale 1ns/1ps
module tb_core_reset_seq;
  import core_reset_pkg::*;

  localparam int N   = 3;
  localparam int REL [0:N-1] = '{0, 4, 10};
  localparam int LF  = 8;
  localparam int SW  = 16;
  localparam int CB  = 2;
  localparam int W   = N + 1 + CB;
  localparam int CNT_MAX = (1 << CB) - 1;
`ifdef CORE_RESET_SEQ_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n, pll_locked, sw_rst_req;
  logic [N-1:0]     srsts;
  logic             seq_done;
  logic [CB-1:0]    loss_cnt;
  reset_seq_state_t dbg_state;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  core_reset_seq #(
    .NUM_OUTPUTS(N), .RELEASE_CLKS(REL), .LOCK_FILT_CLKS(LF),
    .SW_RST_CLKS(SW), .LOSS_CNT_BITS(CB)
  ) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_pll_locked(pll_locked),
    .i_sw_rst_req(sw_rst_req), .o_srsts(srsts), .o_seq_done(seq_done),
    .o_lock_loss_cnt(loss_cnt), .o_dbg_state(dbg_state)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  logic [W-1:0] last_v;
  int           m_cnt;
  int           max_rel;
  int           n_tests = 0;
  int           n_fail  = 0;

  function automatic logic [W-1:0] mk(input logic [N-1:0] s, input logic d);
    return {s, d, CB'(m_cnt)};
  endfunction

  task automatic push_ev(input int t, input logic [W-1:0] v);
    if (v !== last_v) begin
      exp_q.push_back(v);
      exp_t_q.push_back(t);
      last_v = v;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Release rule: bit i is high until REL[i]+1 edges after entry; done after the last one.
  task automatic model_release(input int e, input int tmax);
    logic [N-1:0] s;
    for (int t = 1; t <= tmax; t++) begin
      for (int i = 0; i < N; i++) s[i] = (t <= REL[i]);
      push_ev(e + t, mk(s, t == max_rel + 1));
    end
  endtask

  function automatic bit is_rel_edge(input int t);
    for (int i = 0; i < N; i++) if (REL[i] + 1 == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic count_loss();
    if (CNT_EN && m_cnt < CNT_MAX) m_cnt++;
  endtask

  // driver tasks
  task automatic lock_up();
    int e;
    pll_locked = 1'b1;
    e = cyc + 2 + LF;
    model_release(e, max_rel + 1);
    tick(e + max_rel + 1 - cyc + $urandom_range(1, 6));
  endtask

  task automatic glitch_lock_up();
    int ng;
    ng = $urandom_range(1, 2);
    for (int k = 0; k < ng; k++) begin
      pll_locked = 1'b1;
      tick($urandom_range(1, LF - 1));
      pll_locked = 1'b0;
      tick($urandom_range(1, 4));
    end
    lock_up();
  endtask

  task automatic lock_loss_op();
    int c;
    c = cyc;
    pll_locked = 1'b0;
    count_loss();
    push_ev(c + 3, mk('1, 1'b0));
    tick($urandom_range(3, 10));
    lock_up();
  endtask

  task automatic sw_op();
    int c, k;
    c = cyc;
    k = $urandom_range(1, 8);
    sw_rst_req = 1'b1;
    push_ev(c + 1, mk('1, 1'b0));
    model_release(c + 1 + SW, max_rel + 1);
    tick(k);
    sw_rst_req = 1'b0;
    tick(c + 1 + SW + max_rel + 1 - cyc + $urandom_range(1, 6));
  endtask

  task automatic simul_op();
    int c;
    c = cyc;
    pll_locked = 1'b0;
    count_loss();
    push_ev(c + 3, mk('1, 1'b0));
    tick(2);
    sw_rst_req = 1'b1;
    tick(1);
    sw_rst_req = 1'b0;
    tick($urandom_range(2, 8));
    lock_up();
  endtask

  task automatic arst_op();
    int c, e, j;
    c = cyc;
    pll_locked = 1'b0;
    count_loss();
    push_ev(c + 3, mk('1, 1'b0));
    tick($urandom_range(3, 8));
    pll_locked = 1'b1;
    e = cyc + 2 + LF;
    do j = $urandom_range(2, max_rel); while (is_rel_edge(j));
    model_release(e, j);
    tick(e + j - cyc);
    rst_n = 1'b0;
    pll_locked = 1'b0;
    m_cnt = 0;
    push_ev(cyc, mk('1, 1'b0));
    tick(3);
    rst_n = 1'b1;
    tick($urandom_range(1, 5));
    lock_up();
  endtask

  // monitor: every change of the output vector consumes one expected event
  logic [W-1:0] prev_v;
  bit           seen_first = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] cur, ev;
    int t;
    cur = {srsts, seq_done, loss_cnt};
    if (!seen_first || cur !== prev_v) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no_change", cyc, cur);
      end else begin
        ev = exp_q.pop_front();
        t  = exp_t_q.pop_front();
        if (cur !== ev || (t >= 0 && t != cyc)) begin
          n_fail++;
          $display("FAIL out_event got=%b@cyc%0d required=%b@cyc%0d", cur, cyc, ev, t);
        end
      end
      prev_v     = cur;
      seen_first = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    sw_rst_req = 1'b0;
    m_cnt = 0;
    max_rel = 0;
    for (int i = 0; i < N; i++) if (REL[i] > max_rel) max_rel = REL[i];
    last_v = mk('1, 1'b0);
    exp_q.push_back(last_v);
    exp_t_q.push_back(-1);
    tick(3);
    rst_n = 1'b1;
    tick($urandom_range(2, 6));

    glitch_lock_up();
    sw_op();
    lock_loss_op();
    simul_op();
    repeat (3) lock_loss_op();
    repeat (4) begin
      op = $urandom_range(0, 2);
      case (op)
        0:       sw_op();
        1:       lock_loss_op();
        default: simul_op();
      endcase
    end
    arst_op();
    sw_op();
    tick(5);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events remaining=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_reset_seq.md
# core_reset_seq

Parametrised reset sequencer for the FPGA core clocking/reset layer. It generates NUM_OUTPUTS active-high synchronous resets in one clock domain and releases them in a staggered order once the PLL lock has been stable for a filter period. All outputs are re-asserted on lock loss or on a software reset request, and lock-loss events are counted. It replaces the fixed per-domain reset generators inside the core wrapper: one instance per clock domain.

## Interface
- NUM_OUTPUTS, 1: number of synchronous reset outputs.
- RELEASE_CLKS [0:NUM_OUTPUTS-1], '{default:0}: release offset per output, in clocks after entry to RELEASE; any order allowed.
- LOCK_FILT_CLKS, 16: consecutive synchronised-lock-high cycles required before sequencing; minimum 1.
- SW_RST_CLKS, 16: cycles all outputs are held in SWRST; minimum 1.
- LOSS_CNT_BITS, 8: width of the lock-loss counter.
- i_clk, input, 1: domain clock (PLL output).
- i_arst_n, input, 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- i_pll_locked, input, 1: PLL lock, asynchronous to i_clk.
- i_sw_rst_req, input, 1: synchronous software reset request, level or pulse.
- o_srsts, output, NUM_OUTPUTS: active-high resets, registered.
- o_seq_done, output, 1: high in RUN only.
- o_lock_loss_cnt, output, LOSS_CNT_BITS: saturating count of lock-loss events.

## Operation
- States: HOLD, RELEASE, RUN, SWRST. Reset state is HOLD.
- Lock path: i_pll_locked passes through a 2-FF synchroniser to give lock_s. The synchroniser flops reset to 0.
- **HOLD**
  - filt_cnt increments while lock_s=1 and clears when lock_s=0.
  - Go to RELEASE on the cycle filt_cnt reaches LOCK_FILT_CLKS.
  - All outputs are asserted.
- **RELEASE**
  - rel_cnt is cleared on entry and increments each cycle.
  - o_srsts[i] deasserts when rel_cnt == RELEASE_CLKS[i] and stays low.
  - Go to RUN when rel_cnt == MAX(RELEASE_CLKS).
- **RUN**
  - o_seq_done=1, all outputs low.
- **SWRST**
  - All outputs asserted; sw_cnt counts to SW_RST_CLKS-1, then go to RELEASE.
- Lock loss: lock_s=0 in RELEASE, RUN or SWRST causes the following:
  - next state is HOLD;
  - all o_srsts=1 and o_seq_done=0 at the next edge;
  - o_lock_loss_cnt increments and saturates at all-ones.
- Software reset: i_sw_rst_req=1 in RELEASE or RUN → SWRST, with all outputs asserted at the next edge. The request is ignored in HOLD and SWRST; it is not queued.
- Simultaneous lock loss and software request: lock loss wins (HOLD, counter increments).
- Re-assertion is always simultaneous for all outputs; release always follows the RELEASE_CLKS order.
- Counter widths: $clog2 of (max value + 1), minimum 1 bit.

## Timing
- Reset values:
  - o_srsts all ones, o_seq_done=0, o_lock_loss_cnt=0, state HOLD, all counters 0.
  - Assertion is immediate and asynchronous on i_arst_n low; deassertion only through the sequence.
- Lock latency: i_pll_locked rising to entry into RELEASE is 2 sync cycles + LOCK_FILT_CLKS cycles.
- Release latency: o_srsts[i] falls RELEASE_CLKS[i]+1 edges after the edge that enters RELEASE.
- Lock-loss latency: i_pll_locked falling to o_srsts high is 3 edges (2 sync + 1 register).
- Software-reset latency: request sampled at edge N → outputs high after edge N; RELEASE is entered SW_RST_CLKS edges later.
- A lock glitch shorter than LOCK_FILT_CLKS during HOLD restarts the filter.

## Configuration
- CORE_RESET_SEQ_LOSS_CNT_EN defined: the lock-loss counter is implemented as described.
- Not defined: the counter is not built and o_lock_loss_cnt is tied to 0. All other behaviour is identical.

## Structure
- Package core_reset_pkg holds:
  - typedef enum logic [1:0] {HOLD, RELEASE, RUN, SWRST} reset_seq_state_t;
  - a function computing the maximum of RELEASE_CLKS.
- Sub-module core_bit_sync: parametrised-depth (default 2) single-bit synchroniser with async active-low reset and a reset-value parameter.

## Test plan
- Test configuration: NUM_OUTPUTS=3, RELEASE_CLKS={0,4,10}, LOCK_FILT_CLKS=8.
- Lock and release: lock rises and stays high → RELEASE entered 10 cycles later; o_srsts bits fall 1, 5 and 11 edges after entry; o_seq_done=1 at edge 11.
- Lock glitch: lock high 5 cycles, low 1, then high → release only after 8 further consecutive high cycles.
- Lock loss in RUN: drop lock → all o_srsts=1 three edges later; o_lock_loss_cnt=1; full sequence reruns after lock returns.
- Software request in RUN, SW_RST_CLKS=16: one-cycle pulse → outputs high at the next edge; RELEASE after 16 cycles; same staggered release follows.
- Simultaneous lock drop and software request in RUN → HOLD, count increments by 1, no SWRST entry.
- Saturation and reset:
  - with LOSS_CNT_BITS=2, 5 lock losses → count stays at 3;
  - i_arst_n low mid-RELEASE → all outputs high immediately and the count clears;
  - macro undefined → count reads 0 throughout.
